// File: rtl/spectrum_line_feeder_pkg.sv
// Shared sizes, write-FSM encoding, RAM write payload and the magnitude clamp
// for the spectrum line feeder.
package spectrum_line_feeder_pkg;

    localparam int unsigned NUM_LINES  = 64;
    localparam int unsigned ADDR_W     = 6;
    localparam int unsigned WA_W       = ADDR_W + 1;
    localparam int unsigned LINE_W     = 7;
    localparam int unsigned H_LCD_DISP = 480;
    localparam int unsigned MAG_W      = 16;
    localparam int unsigned LEN_W      = 11;

    typedef enum logic [0:0] {
        W_FILL = 1'b0,
        W_PEND = 1'b1
    } wr_state_e;

    // One RAM write: {bank, line} address plus the clamped bar length
    typedef struct packed {
        logic [WA_W-1:0]  addr;
        logic [LEN_W-1:0] data;
    } ram_wr_t;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [MAG_W-1:0] v);
        if (v > MAG_W'(H_LCD_DISP - 1)) begin
            return LEN_W'(H_LCD_DISP - 1);
        end
        return v[LEN_W-1:0];
    endfunction

endpackage

// File: rtl/spectrum_line_feeder_dpram.sv
// Two-bank simple dual-port RAM holding bar lengths; synchronous read whose
// output register can be forced to zero while no frame has been displayed yet.
module spectrum_line_feeder_dpram
    import spectrum_line_feeder_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  ram_wr_t          i_wr,
    input  logic             i_rd_en,
    input  logic             i_rd_clr,
    input  logic [WA_W-1:0]  i_rd_addr,
    output logic [LEN_W-1:0] o_rd_data
);

    logic [LEN_W-1:0] r_mem [2*NUM_LINES];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr.addr] <= i_wr.data;
        end
    end

    // Read register holds its value between read strobes
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rd_data <= '0;
        end else if (i_rd_en) begin
            o_rd_data <= i_rd_clr ? '0 : r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/spectrum_line_feeder.sv
// Double-buffered bar-length store between the FFT magnitude stream and the LCD
// spectrum display; banks swap only when the display wraps its last line.
module spectrum_line_feeder
    import spectrum_line_feeder_pkg::*;
#(
    parameter int unsigned MAG_SHIFT = 0
) (
    input  logic              lcd_clk,
    input  logic              sys_rst,
    input  logic              mag_valid,
    input  logic [MAG_W-1:0]  mag_data,
    input  logic              mag_last,
    input  logic              data_req,
    input  logic              wr_over,
    output logic [LINE_W-1:0] line_cnt,
    output logic [MAG_W-1:0]  line_length,
    output logic              frame_drop
);

    wr_state_e        r_state;
    wr_state_e        w_state_nxt;
    logic [WA_W-1:0]  r_wr_addr;
    logic [WA_W-1:0]  w_wr_addr_nxt;
    logic             w_drop_nxt;
    logic             r_front;
    logic             r_front_valid;
    logic             w_last_line;
    logic             w_swap;
    logic             w_wr_en;
    logic [MAG_W-1:0] w_shifted;
    ram_wr_t          w_wr;
    logic [WA_W-1:0]  w_rd_addr;
    logic [LEN_W-1:0] w_rd_data;

    assign w_last_line = (line_cnt == LINE_W'(NUM_LINES - 1));
    assign w_swap      = wr_over && w_last_line && (r_state == W_PEND);
    assign w_shifted   = mag_data >> MAG_SHIFT;
    assign w_wr_en     = mag_valid && (r_state == W_FILL) && (r_wr_addr < WA_W'(NUM_LINES));

    // Writes always target the back bank, using the pre-swap bank select
    assign w_wr.addr   = {~r_front, r_wr_addr[ADDR_W-1:0]};
    assign w_wr.data   = clamp_len(w_shifted);
    assign w_rd_addr   = {r_front, line_cnt[ADDR_W-1:0]};

    always_ff @(posedge lcd_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= W_FILL;
            r_wr_addr  <= '0;
            frame_drop <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            frame_drop <= w_drop_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_wr_addr_nxt = r_wr_addr;
        w_drop_nxt    = 1'b0;
        case (r_state)
            W_FILL: begin
                if (mag_valid) begin
                    if (w_wr_en) begin
                        w_wr_addr_nxt = r_wr_addr + WA_W'(1);
                    end
                    if (mag_last) begin
                        w_state_nxt   = W_PEND;
                        w_wr_addr_nxt = '0;
                    end
                end
            end
            W_PEND: begin
                w_drop_nxt = mag_valid && mag_last;
                if (w_swap) begin
                    w_state_nxt = W_FILL;
                end
            end
            default: begin
                w_state_nxt = W_FILL;
            end
        endcase
    end

    // Display line counter and front-bank select
    always_ff @(posedge lcd_clk or posedge sys_rst) begin
        if (sys_rst) begin
            line_cnt      <= '0;
            r_front       <= 1'b0;
            r_front_valid <= 1'b0;
        end else begin
            if (wr_over) begin
                line_cnt <= w_last_line ? '0 : line_cnt + LINE_W'(1);
            end
            if (w_swap) begin
                r_front       <= ~r_front;
                r_front_valid <= 1'b1;
            end
        end
    end

    spectrum_line_feeder_dpram u_dpram (
        .i_clk     (lcd_clk),
        .i_rst     (sys_rst),
        .i_wr_en   (w_wr_en),
        .i_wr      (w_wr),
        .i_rd_en   (data_req),
        .i_rd_clr  (~r_front_valid),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign line_length = MAG_W'(w_rd_data);

endmodule

// File: tb/tb_spectrum_line_feeder.sv
// Directed bench for spectrum_line_feeder: a default instance and a MAG_SHIFT=2
// instance share all stimulus; expected bar lengths are hand-computed.
module tb_spectrum_line_feeder;

    logic        lcd_clk;
    logic        sys_rst;
    logic        mag_valid;
    logic [15:0] mag_data;
    logic        mag_last;
    logic        data_req;
    logic        wr_over;
    logic [6:0]  line_cnt;
    logic [15:0] line_length;
    logic        frame_drop;
    logic [6:0]  line_cnt_s2;
    logic [15:0] line_length_s2;
    logic        frame_drop_s2;

    int vecs;
    int errs;
    int tb_line;

    spectrum_line_feeder #(.MAG_SHIFT(0)) u_dut (
        .lcd_clk     (lcd_clk),
        .sys_rst     (sys_rst),
        .mag_valid   (mag_valid),
        .mag_data    (mag_data),
        .mag_last    (mag_last),
        .data_req    (data_req),
        .wr_over     (wr_over),
        .line_cnt    (line_cnt),
        .line_length (line_length),
        .frame_drop  (frame_drop)
    );

    spectrum_line_feeder #(.MAG_SHIFT(2)) u_dut_s2 (
        .lcd_clk     (lcd_clk),
        .sys_rst     (sys_rst),
        .mag_valid   (mag_valid),
        .mag_data    (mag_data),
        .mag_last    (mag_last),
        .data_req    (data_req),
        .wr_over     (wr_over),
        .line_cnt    (line_cnt_s2),
        .line_length (line_length_s2),
        .frame_drop  (frame_drop_s2)
    );

    initial begin
        lcd_clk = 1'b0;
        forever #5 lcd_clk = ~lcd_clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge lcd_clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] d, input logic last);
        mag_valid = 1'b1;
        mag_data  = d;
        mag_last  = last;
        tick();
        mag_valid = 1'b0;
        mag_data  = '0;
        mag_last  = 1'b0;
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) begin
            wr_over = 1'b1;
            tick();
            wr_over = 1'b0;
            tb_line = (tb_line == 63) ? 0 : tb_line + 1;
        end
    endtask

    task automatic read_chk(input string tag, input logic [15:0] exp0, input logic [15:0] exp2);
        data_req = 1'b1;
        tick();
        data_req = 1'b0;
        check(tag, line_length, exp0);
        check({tag, "_s2"}, line_length_s2, exp2);
    endtask

    initial begin
        vecs      = 0;
        errs      = 0;
        tb_line   = 0;
        sys_rst   = 1'b1;
        mag_valid = 1'b0;
        mag_data  = '0;
        mag_last  = 1'b0;
        data_req  = 1'b0;
        wr_over   = 1'b0;
        tick();
        tick();
        sys_rst = 1'b0;
        tick();
        check("rst_line_cnt", 16'(line_cnt), 16'd0);
        check("rst_line_length", line_length, 16'd0);
        check("rst_frame_drop", 16'(frame_drop), 16'd0);

        // partial frame and some line advances, then asynchronous reset mid-cycle
        for (int i = 0; i < 5; i++) beat(16'd100, 1'b0);
        advance(3);
        check("pre_rst_line_cnt", 16'(line_cnt), 16'(tb_line));
        @(posedge lcd_clk);
        #3;
        sys_rst = 1'b1;
        #1;
        check("async_rst_line_cnt", 16'(line_cnt), 16'd0);
        check("async_rst_line_length", line_length, 16'd0);
        check("async_rst_frame_drop", 16'(frame_drop), 16'd0);
        #2;
        sys_rst = 1'b0;
        tb_line = 0;
        tick();
        read_chk("no_frame_read", 16'd0, 16'd0);

        // frame A: i*8, written into the back bank
        for (int i = 0; i < 64; i++) beat(16'(i * 8), i == 63);
        check("frame_a_no_drop", 16'(frame_drop), 16'd0);
        read_chk("pre_swap_line0", 16'd0, 16'd0);
        advance(63);
        read_chk("pre_swap_line63", 16'd0, 16'd0);
        advance(1);
        check("swap_wrap_line_cnt", 16'(line_cnt), 16'd0);
        advance(5);
        read_chk("a_line5", 16'd40, 16'd10);
        advance(58);
        check("at_line63", 16'(line_cnt), 16'd63);

        // read and advance in the same cycle on the last line
        data_req = 1'b1;
        wr_over  = 1'b1;
        tick();
        data_req = 1'b0;
        wr_over  = 1'b0;
        tb_line  = 0;
        check("collide_len", line_length, 16'd479);
        check("collide_len_s2", line_length_s2, 16'd126);
        check("collide_line_cnt", 16'(line_cnt), 16'd0);

        // frame B accepted, frame C overruns while pending
        for (int i = 0; i < 64; i++) beat(16'(2 * i + 1), i == 63);
        for (int i = 0; i < 63; i++) beat(16'd7, 1'b0);
        check("overrun_no_early_drop", 16'(frame_drop), 16'd0);
        beat(16'd7, 1'b1);
        check("overrun_drop_pulse", 16'(frame_drop), 16'd1);
        tick();
        check("overrun_drop_clear", 16'(frame_drop), 16'd0);

        // 130 strobes: swap on the first wrap only
        advance(63);
        check("wrap1_line63", 16'(line_cnt), 16'd63);
        read_chk("wrap1_old_frame", 16'd479, 16'd126);
        advance(1);
        check("wrap1_line0", 16'(line_cnt), 16'd0);
        read_chk("wrap1_frame_b_line0", 16'd1, 16'd0);
        advance(64);
        check("wrap2_line0", 16'(line_cnt), 16'd0);
        advance(2);
        check("wrap_end_line2", 16'(line_cnt), 16'd2);
        read_chk("wrap2_frame_b_line2", 16'd5, 16'd1);

        // short frame with clamp/shift values; lines 10..63 keep frame A
        beat(16'hFFFF, 1'b0);
        beat(16'd400, 1'b0);
        for (int i = 2; i < 10; i++) beat(16'd100, i == 9);
        advance(62);
        check("short_swap_line0", 16'(line_cnt), 16'd0);
        read_chk("clamp_ffff", 16'd479, 16'd479);
        advance(1);
        read_chk("shift_400", 16'd400, 16'd100);
        advance(8);
        read_chk("short_line9", 16'd100, 16'd25);
        advance(1);
        read_chk("short_keep_line10", 16'd80, 16'd20);
        advance(53);
        read_chk("short_keep_line63", 16'd479, 16'd126);

        // long frame: beats past the last line are ignored
        for (int i = 0; i < 70; i++) beat((i < 64) ? 16'(200 + i) : 16'd5, i == 69);
        advance(1);
        check("long_swap_line0", 16'(line_cnt), 16'd0);
        read_chk("long_line0", 16'd200, 16'd50);
        advance(63);
        read_chk("long_line63", 16'd263, 16'd65);
        check("final_drop_low", 16'(frame_drop_s2), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
